// File: rtl/memory32x8_bi_master.sv
// Bus initiator for the 32x8 bidirectional-data memory: valid/ready requests in, en/rw/addr/data pins out.
// Optional MEM_BUS_TURNAROUND_EN inserts a one-cycle idle bus gap after every write.
module memory32x8_bi_master #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RSP,
    S_TURN
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              en_q;
  logic              rw_q;
  logic              oe_q;
  logic              rsp_valid_q;

  // Single registered FSM; every pin-facing output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            en_q    <= 1'b1;
            rw_q    <= req_we;
            oe_q    <= req_we;
            state_q <= req_we ? S_WR : S_RD;
          end
        end
        S_WR: begin
          en_q <= 1'b0;
          rw_q <= 1'b0;
          oe_q <= 1'b0;
`ifdef MEM_BUS_TURNAROUND_EN
          state_q <= S_TURN;
`else
          state_q <= S_IDLE;
`endif
        end
        S_RD: begin
          if (RD_LAT == 0) begin
            rsp_data_q  <= mem_data;
            rsp_valid_q <= 1'b1;
            en_q        <= 1'b0;
            state_q     <= S_RSP;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT - 1);
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= mem_data;
            rsp_valid_q <= 1'b1;
            en_q        <= 1'b0;
            state_q     <= S_RSP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_TURN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is gated by rst_n so no request can be taken while reset is held.
  assign req_ready = rst_n && (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_en    = en_q;
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_data  = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory32x8_bi_master.sv
// Self-checking bench for memory32x8_bi_master with a 32x8 memory model (RD_LAT=1) on a pulled-up bus.
module tb_memory32x8_bi_master;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned RSP_AGE = 2 + RD_LAT;
`ifdef MEM_BUS_TURNAROUND_EN
  localparam int unsigned WR_LEN = 2;
`else
  localparam int unsigned WR_LEN = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  wire  [DATA_W-1:0] mem_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  memory32x8_bi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Undriven bus reads as all ones.
  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup (mem_data[i]);
  end

  // Memory device: one-cycle read latency, drives only while the read command is still held.
  logic [DATA_W-1:0] mem_arr [32];
  logic              rd_q = 1'b0;
  logic [DATA_W-1:0] rdat_q = '0;
  wire               mem_drv = rd_q && mem_en && !mem_rw;
  assign mem_data = mem_drv ? rdat_q : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (mem_en && mem_rw) mem_arr[mem_addr] <= mem_data;
    rd_q   <= mem_en && !mem_rw;
    rdat_q <= mem_arr[mem_addr];
  end

  // Transaction timeline model: kind 0 idle, 1 write, 2 read; age counts edges since accept.
  logic [DATA_W-1:0] smem [32];
  int                kind = 0;
  int                age  = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] exp_rsp = '0;
  bit                m_in_rst = 1'b0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = DATA_W'(i * 7 + 3);
      smem[i]    = DATA_W'(i * 7 + 3);
    end
    mem_arr[2] = 8'hA5;
    smem[2]    = 8'hA5;
  end

  always @(posedge clk) begin
    m_in_rst = !rst_n;
    if (!rst_n) begin
      kind = 0; age = 0; m_addr = '0; exp_rsp = '0;
    end else if (kind == 0) begin
      if (req_valid) begin
        kind    = req_we ? 1 : 2;
        age     = 1;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        if (req_we) smem[req_addr] = req_wdata;
      end
    end else if (kind == 2 && age >= RSP_AGE && rsp_ready) begin
      kind = 0;
    end else begin
      age = age + 1;
      if (kind == 1 && age > WR_LEN) kind = 0;
      if (kind == 2 && age == RSP_AGE) exp_rsp = smem[m_addr];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit wr_act, turn, rd_act, rsp_ph;
      wr_act = (kind == 1) && (age == 1);
      turn   = (kind == 1) && (age == 2);
      rd_act = (kind == 2) && (age < RSP_AGE);
      rsp_ph = (kind == 2) && (age >= RSP_AGE);
      check("req_ready", 32'(req_ready), 32'(rst_n && kind == 0));
      check("mem_en", 32'(mem_en), 32'(wr_act || rd_act));
      check("rsp_valid", 32'(rsp_valid), 32'(rsp_ph));
      check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
      if (wr_act || rd_act) begin
        check("mem_rw", 32'(mem_rw), 32'(wr_act));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
      end
      if (turn || m_in_rst) check("mem_rw_idle", 32'(mem_rw), 32'(0));
      if (m_in_rst) check("mem_addr_rst", 32'(mem_addr), 32'(0));
      if (!mem_drv) check("mem_data_bus", 32'(mem_data), wr_act ? 32'(m_wdata) : 32'hFF);
    end
  end

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output int t_acc);
    bit r;
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
    t_acc = cyc;
    if (!ok) check("req_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic get_rsp(input bit early, input int hold, input logic [DATA_W-1:0] exp,
                         input int t0, input string nm);
    bit seen;
    seen = 1'b0;
    rsp_ready = early;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check({nm, "_rsp_timeout"}, 32'(0), 32'(1));
      rsp_ready = 1'b0;
      return;
    end
    check({nm, "_latency"}, 32'(cyc - t0), 32'(2));
    check({nm, "_data"}, 32'(rsp_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(rsp_valid), 32'(1));
      check({nm, "_hold_data"}, 32'(rsp_data), 32'(exp));
      check({nm, "_hold_ready"}, 32'(req_ready), 32'(0));
      check({nm, "_hold_en"}, 32'(mem_en), 32'(0));
    end
    if (!early) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({nm, "_valid_drop"}, 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    // Reset held three edges with a pending request.
    @(posedge clk); #1; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;

    // Write 0x02 to address 1, then read it back with rsp_ready already high.
    do_req(1'b1, 5'd1, 8'h02, t);
    @(negedge clk);
    check("wr_en", 32'(mem_en), 32'(1));
    check("wr_rw", 32'(mem_rw), 32'(1));
    check("wr_addr", 32'(mem_addr), 32'(1));
    check("wr_data", 32'(mem_data), 32'h02);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef MEM_BUS_TURNAROUND_EN
    check("turn_ready", 32'(req_ready), 32'(0));
    check("turn_en", 32'(mem_en), 32'(0));
`else
    check("post_wr_ready", 32'(req_ready), 32'(1));
`endif
    @(posedge clk); #1;
    do_req(1'b0, 5'd1, 8'h00, t);
    get_rsp(1'b1, 0, 8'h02, t, "rd1");

    // Preloaded word under response backpressure.
    do_req(1'b0, 5'd2, 8'h00, t);
    get_rsp(1'b0, 4, 8'hA5, t, "rd2");

    // Back-to-back write then read at the top address.
    do_req(1'b1, 5'd31, 8'hFF, t);
    do_req(1'b0, 5'd31, 8'h00, t);
    get_rsp(1'b0, 0, 8'hFF, t, "rd31");

    // Reset during the read wait cycle aborts the access.
    do_req(1'b0, 5'd5, 8'h00, t);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    check("abort_ready", 32'(req_ready), 32'(1));
    check("abort_en", 32'(mem_en), 32'(0));
    @(posedge clk); #1;
    do_req(1'b0, 5'd5, 8'h00, t);
    get_rsp(1'b0, 0, 8'h26, t, "rd5");

    // Write/read pair back-to-back again for the turnaround path.
    do_req(1'b1, 5'd7, 8'h3C, t);
    do_req(1'b0, 5'd7, 8'h00, t);
    get_rsp(1'b0, 1, 8'h3C, t, "rd7");

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    check("global_timeout", 32'(0), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
